// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the memory-mapped UART transmitter.
//   Register word offsets (addr[3:2]), STATUS bit positions, serialiser
//   state encoding and the minimum usable baud divisor.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_LEVEL = 8;

  localparam logic [15:0] DIV_MIN = 16'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Divisors below DIV_MIN are clamped so a bit always spans >= 2 cycles.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div < DIV_MIN) ? DIV_MIN : div;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO (rdata valid whenever !empty).
//   clk, reset      : clock, synchronous active-high reset (flushes contents)
//   push, wdata     : write request / data; accepted when not full or when
//                     a pop happens in the same cycle
//   pop, rdata      : read request / head-of-queue data
//   full, empty     : occupancy flags
//   level           : number of stored entries (0..DEPTH)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO still takes a push.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mm_uart_tx.sv
// mm_uart_tx: memory-mapped 8N1 UART transmitter on the picorv32 native bus.
//   clk, reset : system clock, synchronous active-high reset
//   select     : slave select from the address decoder
//   wstrb      : byte write strobes (0 = read)
//   addr       : byte offset; addr[3:2] selects DATA/STATUS/DIV/CTRL
//   data_i     : write data
//   ready      : one-cycle transfer-complete pulse
//   data_o     : read data, valid while ready=1, otherwise 0
//   irq        : level "TX complete" interrupt
//   tx         : serial line, idle high
// Build option: define MM_UART_TX_IRQ_EN to enable CTRL.irq_en and irq;
// without it irq is tied low and CTRL reads 0.
module mm_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 27_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        select,
  input  logic [3:0]  wstrb,
  input  logic [3:0]  addr,
  input  logic [31:0] data_i,
  output logic        ready,
  output logic [31:0] data_o,
  output logic        irq,
  output logic        tx
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DIV_RESET = 16'(CLK_HZ / BAUD);

  // ---------------- FIFO ----------------
  logic          push, pop, full, empty;
  logic [7:0]    fifo_rdata;
  logic [AW:0]   level;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (data_i[7:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // ---------------- bus register file ----------------
  logic        ready_q, ready_d;
  logic [31:0] data_o_q, data_o_d;
  logic [15:0] div_q, div_d;
  logic        ctrl_q, ctrl_d;
  logic [31:0] status;
  tx_state_e   state_q, state_d;

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], data_i[31:16]};

  always_comb begin
    status                        = '0;
    status[STAT_BUSY]             = (state_q != ST_IDLE);
    status[STAT_FULL]             = full;
    status[STAT_EMPTY]            = empty;
    status[STAT_LEVEL +: AW+1]    = level;
  end

  // A transfer is taken only while ready is low, so ready is a single-cycle
  // pulse even if select stays high. A DATA write to a full FIFO waits with
  // ready low until the serialiser pops; dropping select meanwhile aborts it.
  always_comb begin
    ready_d  = 1'b0;
    data_o_d = '0;
    div_d    = div_q;
    ctrl_d   = ctrl_q;
    push     = 1'b0;
    if (select && !ready_q) begin
      unique case (addr[3:2])
        REG_DATA: begin
          if (wstrb[0]) begin
            push    = !full || pop;
            ready_d = push;
          end else begin
            ready_d = 1'b1;
          end
        end
        REG_STATUS: begin
          ready_d = 1'b1;
          if (wstrb == 4'd0) data_o_d = status;
        end
        REG_DIV: begin
          ready_d = 1'b1;
          if (wstrb == 4'd0) begin
            data_o_d = {16'd0, div_q};
          end else begin
            if (wstrb[0]) div_d[7:0]  = data_i[7:0];
            if (wstrb[1]) div_d[15:8] = data_i[15:8];
          end
        end
        REG_CTRL: begin
          ready_d = 1'b1;
          if (wstrb == 4'd0) begin
            data_o_d = {31'd0, ctrl_q};
          end
`ifdef MM_UART_TX_IRQ_EN
          else if (wstrb[0]) begin
            ctrl_d = data_i[0];
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q  <= 1'b0;
      data_o_q <= '0;
      div_q    <= DIV_RESET;
      ctrl_q   <= 1'b0;
    end else begin
      ready_q  <= ready_d;
      data_o_q <= data_o_d;
      div_q    <= div_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign ready  = ready_q;
  assign data_o = data_o_q;

`ifdef MM_UART_TX_IRQ_EN
  assign irq = ctrl_q && empty && (state_q == ST_IDLE);
`else
  assign irq = 1'b0;
`endif

  // ---------------- serialiser ----------------
  logic [15:0] cnt_q, cnt_d;     // cycles left in current bit, minus one
  logic [15:0] bdiv_q, bdiv_d;   // divisor latched for the current frame
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic [15:0] div_eff;

  assign div_eff = eff_div(div_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bdiv_q  <= DIV_MIN;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bdiv_q  <= bdiv_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bdiv_d  = bdiv_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_START;
          sh_d    = fifo_rdata;
          bdiv_d  = div_eff;
          cnt_d   = div_eff - 16'd1;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          cnt_d   = bdiv_q - 16'd1;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = bdiv_q - 16'd1;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          // Chain straight into the next start bit when more data is queued.
          if (!empty) begin
            pop     = 1'b1;
            state_d = ST_START;
            sh_d    = fifo_rdata;
            bdiv_d  = div_eff;
            cnt_d   = div_eff - 16'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      ST_START: tx = 1'b0;
      ST_DATA:  tx = sh_q[0];
      default:  tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mm_uart_tx.sv
// tb_mm_uart_tx: scoreboard bench for mm_uart_tx. Written bytes are queued
// with the divisor their frame must use; a line monitor pops each entry at
// the start bit and checks the whole frame cycle by cycle.
module tb_mm_uart_tx;

  logic        clk, reset, select, ready, irq, tx;
  logic [3:0]  wstrb, addr;
  logic [31:0] data_i, data_o;

  localparam logic [3:0] A_DATA = 4'h0, A_STAT = 4'h4, A_DIV = 4'h8, A_CTRL = 4'hC;

  mm_uart_tx dut (
    .clk(clk), .reset(reset), .select(select), .wstrb(wstrb), .addr(addr),
    .data_i(data_i), .ready(ready), .data_o(data_o), .irq(irq), .tx(tx)
  );

  typedef struct { logic [7:0] data; int div; } exp_t;
  exp_t sb[$];
  int   starts[$];
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, frames_done = 0;
  bit   mon_busy = 0;

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic [3:0] a, input logic [3:0] ws, input logic [31:0] d,
                     output logic [31:0] rdat, output int lat);
    select = 1'b1; addr = a; wstrb = ws; data_i = d; lat = 0; rdat = '0;
    do begin @(posedge clk); #1; lat++; end while (!ready && lat < 2000);
    if (!ready) chk("bus_timeout", 32'd0, 32'd1);
    else rdat = data_o;
    select = 1'b0; wstrb = 4'd0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] r; int l;
    bus(a, 4'hF, d, r, l);
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] r; int l;
    bus(a, 4'h0, 32'd0, r, l);
    chk(tag, r, exp);
  endtask

  task automatic send(input logic [7:0] b, input int div, output int lat);
    logic [31:0] r;
    exp_t e;
    e.data = b; e.div = div;
    sb.push_back(e);
    bus(A_DATA, 4'h1, {24'd0, b}, r, lat);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || mon_busy) && n < 5000) begin @(posedge clk); #1; n++; end
    if (n >= 5000) chk("drain_timeout", 32'd0, 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Line monitor: checks every cycle of each frame against the expected
  // waveform and decodes the byte at bit centres.
  initial begin : mon
    exp_t e;
    logic [7:0] b;
    int errs, bi;
    bit aborted;
    logic expbit;
    forever begin
      @(posedge clk); #1;
      if (!reset && tx === 1'b0) begin
        mon_busy = 1;
        if (sb.size() == 0) begin
          chk("unexp_frame", 32'd1, 32'd0);
          e.data = 8'h00; e.div = 4;
        end else begin
          e = sb.pop_front();
        end
        starts.push_back(cyc);
        errs = 0; aborted = 0; b = '0;
        for (int c = 0; c < 10 * e.div; c++) begin
          if (c > 0) begin @(posedge clk); #1; end
          if (reset) begin aborted = 1; break; end
          bi = c / e.div;
          expbit = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : e.data[bi-1];
          if (tx !== expbit) errs++;
          if (bi >= 1 && bi <= 8 && (c % e.div) == e.div / 2) b[bi-1] = tx;
        end
        if (!aborted) begin
          chk("frame_data", {24'd0, b}, {24'd0, e.data});
          chk("frame_timing", errs, 32'd0);
          frames_done++;
        end
        mon_busy = 0;
      end
    end
  end

  initial begin : main
    int lat, rise, nf;
    logic [31:0] r;
    reset = 1'b1; select = 1'b0; wstrb = '0; addr = '0; data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_irq", irq, 0);
    chk("rst_ready", ready, 0);
    chk("rst_data_o", data_o, 0);
    reset = 1'b0;
    rd("rst_status", A_STAT, 32'h4);
    rd("rst_div", A_DIV, 32'd234);
    rd("rst_ctrl", A_CTRL, 32'd0);

    // DIV byte-strobe write keeps the untouched byte
    wr(A_DIV, 32'd4);
    bus(A_DIV, 4'b0010, 32'h0000_AB00, r, lat);
    rd("div_strobe", A_DIV, 32'h0000_AB04);
    wr(A_DIV, 32'd4);

    // busy still set 40 cycles after push, clear one cycle later
    send(8'h55, 4, lat);
    repeat (40) @(posedge clk);
    #1;
    rd("busy_40", A_STAT, 32'h5);
    drain();
    send(8'h55, 4, lat);
    repeat (41) @(posedge clk);
    #1;
    rd("busy_41", A_STAT, 32'h4);
    drain();

    // back-to-back frames: no idle gap
    starts.delete();
    send(8'hA5, 4, lat);
    send(8'h3C, 4, lat);
    drain();
    if (starts.size() >= 2) chk("b2b_gap", starts[1] - starts[0], 40);
    else chk("b2b_frames", starts.size(), 2);

    // burst: the first byte is popped at once, so 17 writes fit; the 18th
    // stalls until the STOP->START pop of the first frame.
    for (int i = 0; i < 17; i++) begin
      send(8'(i * 13 + 7), 4, lat);
      chk("burst_lat", lat, (i == 0) ? 1 : 2);
    end
    send(8'hE1, 4, lat);
    chk("stall_lat", lat, 9);
    rd("full_status", A_STAT, 32'h1003);
    drain();
    rd("drained_status", A_STAT, 32'h4);

    // DIV below minimum clamps to 2-cycle bits
    wr(A_DIV, 32'd1);
    rd("div1_rd", A_DIV, 32'd1);
    send(8'h96, 2, lat);
    drain();

    // DIV change mid-frame only affects the next frame
    wr(A_DIV, 32'd4);
    send(8'h0F, 4, lat);
    repeat (10) @(posedge clk);
    #1;
    wr(A_DIV, 32'd6);
    send(8'hC3, 6, lat);
    drain();
    wr(A_DIV, 32'd4);

`ifdef MM_UART_TX_IRQ_EN
    wr(A_CTRL, 32'd1);
    rd("ctrl_rd", A_CTRL, 32'd1);
    chk("irq_idle", irq, 1);
    starts.delete();
    send(8'h5A, 4, lat);
    chk("irq_clr_push", irq, 0);
    rise = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (irq) begin rise = cyc; break; end
    end
    if (rise < 0 || starts.size() == 0) chk("irq_rise_timeout", 32'd0, 32'd1);
    else chk("irq_rise_cyc", rise - starts[0], 40);
    send(8'h00, 4, lat);
    chk("irq_clr_data", irq, 0);
    drain();
    chk("irq_done", irq, 1);
    wr(A_CTRL, 32'd0);
    chk("irq_dis", irq, 0);
`else
    wr(A_CTRL, 32'd1);
    rd("ctrl_rd0", A_CTRL, 32'd0);
    send(8'h5A, 4, lat);
    drain();
    chk("irq_tied", irq, 0);
`endif

    // reset mid-frame: line idles next cycle, FIFO flushed, nothing more sent
    send(8'h11, 4, lat);
    send(8'h22, 4, lat);
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    chk("rst_mid_tx", tx, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    nf = frames_done;
    rd("rst_mid_status", A_STAT, 32'h4);
    rd("rst_mid_div", A_DIV, 32'd234);
    repeat (100) @(posedge clk);
    #1;
    chk("rst_mid_noframe", frames_done, nf);
    chk("rst_mid_tx_idle", tx, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
